// File: rtl/fifo_stream_pkg.sv
// Shared widths and word layout for the async_fifo read-side stream adapter.
package fifo_stream_pkg;

  localparam int unsigned FIFO_DATA_W = 9;
  localparam int unsigned LAST_BIT    = 8;
  localparam int unsigned PAYLOAD_W   = FIFO_DATA_W - 1;

  typedef logic [PAYLOAD_W-1:0] payload_t;

  typedef struct packed {
    logic     last;
    payload_t data;
  } fifo_word_t;

endpackage

// File: rtl/stream_ring_buf.sv
// Circular buffer with occupancy level; non-power-of-two depths wrap explicitly.
module stream_ring_buf #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rdata = mem[rd_ptr];

  // Storage, pointers and level; pop is only ever requested while level != 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      assert (level <= LVL_W'(DEPTH))
        else $error("stream_ring_buf level %0d exceeds depth %0d", level, DEPTH);
      assert (!(push && !pop && level == LVL_W'(DEPTH)))
        else $error("stream_ring_buf push into full buffer");
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the async_fifo registered-read interface into a valid/ready stream
// using credit-based prefetch into a small ring buffer.
module fifo_rd_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned LVL_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_read_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-2:0] m_data,
  output logic              m_last,
  output logic [LVL_W-1:0]  buf_level,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned IF_W  = $clog2(RD_LAT + 1);
  localparam int unsigned SUM_W = LVL_W + 1;

  if (RD_LAT < 1 || BUF_DEPTH < RD_LAT + 1) begin : g_bad_cfg
    $error("fifo_rd_stream_adapter: need RD_LAT >= 1 and BUF_DEPTH >= RD_LAT+1");
  end

  logic              run;
  logic [RD_LAT-1:0] pipe;
  logic [IF_W-1:0]   inflight;
  logic [DATA_W-1:0] head;
  logic              pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IF_W'(pipe[i]);
  end

  // Credit counts words already buffered plus words still in flight; a same-cycle
  // pop is deliberately not credited so m_ready never reaches fifo_read_en.
  always_comb begin
    fifo_read_en = run && !fifo_empty &&
                   ((SUM_W'(buf_level) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH));
  end

  assign pop     = m_valid && m_ready;
  assign m_valid = (buf_level != '0);
  assign m_data  = head[DATA_W-2:0];
  assign m_last  = head[DATA_W-1];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run       <= 1'b0;
      pipe      <= '0;
      frame_cnt <= '0;
    end else begin
      run  <= 1'b1;
      pipe <= RD_LAT'({pipe, fifo_read_en});
      if (pop && m_last) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  stream_ring_buf #(
    .W     (DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (rclk),
    .rst_n (rrst_n),
    .push  (pipe[RD_LAT-1]),
    .pop   (pop),
    .wdata (fifo_rdata),
    .rdata (head),
    .level (buf_level)
  );

endmodule
